// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin share of one ALU between two requesters.
// A granted request is captured, held on the ALU pins until C_en, and the
// result is returned through a per-port valid/ready response.
// Optional feature: define ALU_ARB_TIMEOUT_EN to abort a BUSY op after
// TIMEOUT cycles without C_en, answering with rsp_err=1 and rsp_c=0.
module alu_req_arbiter #(
  parameter int DATA_W  = 5,
  parameter int RES_W   = 6,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  input  logic [1:0]          req_a_en,
  input  logic [5:0]          req_a_op,
  input  logic [1:0]          req_b_en,
  input  logic [3:0]          req_b_op,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [RES_W-1:0]    rsp_c,
  output logic                rsp_err,
  output logic                ALU_en,
  output logic [DATA_W-1:0]   A,
  output logic [DATA_W-1:0]   B,
  output logic                a_en,
  output logic [2:0]          a_op,
  output logic                b_en,
  output logic [1:0]          b_op,
  input  logic                C_en,
  input  logic [RES_W-1:0]    C
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t state;
  logic   last_grant;  // port granted most recently; the other port has priority
  logic   gnt;         // port owning the op in flight
  logic   grant;       // port that would be granted this cycle

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt;
`else
  assign rsp_err = 1'b0;
`endif

  assign grant = req_valid[~last_grant] ? ~last_grant : last_grant;

  // Accept in IDLE only; gated by reset so ready is low while reset is held.
  always_comb begin
    req_ready = 2'b00;
    if (rst_n && state == IDLE && |req_valid) req_ready[grant] = 1'b1;
  end

  // Main FSM; the ALU pins and response outputs are the captured registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      ALU_en     <= 1'b0;
      A          <= '0;
      B          <= '0;
      a_en       <= 1'b0;
      a_op       <= '0;
      b_en       <= 1'b0;
      b_op       <= '0;
      rsp_valid  <= 2'b00;
      rsp_c      <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
      rsp_err    <= 1'b0;
      cnt        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            gnt        <= grant;
            last_grant <= grant;
            ALU_en     <= 1'b1;
            A          <= grant ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
            B          <= grant ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
            a_en       <= req_a_en[grant];
            a_op       <= grant ? req_a_op[5:3] : req_a_op[2:0];
            b_en       <= req_b_en[grant];
            b_op       <= grant ? req_b_op[3:2] : req_b_op[1:0];
            state      <= BUSY;
`ifdef ALU_ARB_TIMEOUT_EN
            cnt        <= '0;
`endif
          end
        end
        BUSY: begin
          if (C_en) begin
            rsp_c     <= C;
`ifdef ALU_ARB_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            rsp_valid <= gnt ? 2'b10 : 2'b01;
            ALU_en    <= 1'b0;
            A         <= '0;
            B         <= '0;
            a_en      <= 1'b0;
            a_op      <= '0;
            b_en      <= 1'b0;
            b_op      <= '0;
            state     <= RESP;
          end
`ifdef ALU_ARB_TIMEOUT_EN
          else if (cnt == TO_LAST) begin
            rsp_c     <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= gnt ? 2'b10 : 2'b01;
            ALU_en    <= 1'b0;
            A         <= '0;
            B         <= '0;
            a_en      <= 1'b0;
            a_op      <= '0;
            b_en      <= 1'b0;
            b_op      <= '0;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready[gnt]) begin
            rsp_valid <= 2'b00;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: transaction-level model of round-robin grant
// order and result return, with a behavioural ALU responder of random latency.
module tb_alu_req_arbiter;
  localparam int DW = 5;
  localparam int RW = 6;
  localparam int TO = 15;

  logic clk, rst_n;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2*DW-1:0] req_a, req_b;
  logic [1:0] req_a_en, req_b_en;
  logic [5:0] req_a_op;
  logic [3:0] req_b_op;
  logic [RW-1:0] rsp_c, C;
  logic rsp_err, ALU_en, a_en, b_en, C_en;
  logic [DW-1:0] A, B;
  logic [2:0] a_op;
  logic [1:0] b_op;

  // per-port operand sets presented by the requesters
  logic [DW-1:0] oa [2];
  logic [DW-1:0] ob [2];
  logic          oae[2];
  logic [2:0]    oao[2];
  logic          obe[2];
  logic [1:0]    obo[2];
  logic [RW-1:0] cval;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic m_last;  // model: port granted last

  assign req_a    = {oa[1], oa[0]};
  assign req_b    = {ob[1], ob[0]};
  assign req_a_en = {oae[1], oae[0]};
  assign req_a_op = {oao[1], oao[0]};
  assign req_b_en = {obe[1], obe[0]};
  assign req_b_op = {obo[1], obo[0]};

  alu_req_arbiter #(.DATA_W(DW), .RES_W(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_a_en(req_a_en), .req_a_op(req_a_op),
    .req_b_en(req_b_en), .req_b_op(req_b_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_c(rsp_c), .rsp_err(rsp_err), .ALU_en(ALU_en),
    .A(A), .B(B), .a_en(a_en), .a_op(a_op), .b_en(b_en), .b_op(b_op),
    .C_en(C_en), .C(C)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic rand_ops;
    for (int p = 0; p < 2; p++) begin
      oa[p]  = DW'($urandom);
      ob[p]  = DW'($urandom);
      oae[p] = 1'($urandom);
      oao[p] = 3'($urandom);
      obe[p] = 1'($urandom);
      obo[p] = 2'($urandom);
    end
    cval = RW'($urandom);
  endtask

  // Model grant: the port that did not win last time has priority.
  function automatic int exp_port(input logic [1:0] vm);
    if (vm[!m_last]) return (!m_last) ? 1 : 0;
    return m_last ? 1 : 0;
  endfunction

  // One full transaction: handshake, lat BUSY cycles (C_en on the last),
  // RESP held for hold cycles before rsp_ready on the granted port.
  task automatic run_op(input logic [1:0] vm, input int lat, input int hold, output int port);
    int e;
    logic [1:0] oh;
    e  = exp_port(vm);
    oh = (e == 1) ? 2'b10 : 2'b01;
    req_valid = vm; C_en = 1'b0; #1;
    n_tests++;
    if (req_ready !== oh || ALU_en !== 1'b0) begin
      n_fail++;
      $display("FAIL grant: req_ready=%b ALU_en=%b, expected req_ready=%b ALU_en=0", req_ready, ALU_en, oh);
    end
    step;
    m_last = e[0]; port = e;
    req_valid = 2'b00;  // dropping valid after capture must not matter
    for (int i = 0; i < lat; i++) begin
      C_en = (i == lat - 1); C = cval; #1;
      n_tests++;
      if (ALU_en !== 1'b1 || A !== oa[e] || B !== ob[e] || a_en !== oae[e] || a_op !== oao[e] ||
          b_en !== obe[e] || b_op !== obo[e] || req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
        n_fail++;
        $display("FAIL busy_pins: en=%b A=%h B=%h ae=%b ao=%h be=%b bo=%h rdy=%b rv=%b, expected en=1 A=%h B=%h ae=%b ao=%h be=%b bo=%h rdy=00 rv=00",
                 ALU_en, A, B, a_en, a_op, b_en, b_op, req_ready, rsp_valid, oa[e], ob[e], oae[e], oao[e], obe[e], obo[e]);
      end
      step;
    end
    C_en = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      rsp_ready = (h == hold) ? oh : ~oh;  // non-granted ready must be ignored
      req_valid = 2'b11;                   // no new grant while responding
      C_en = 1'($urandom); C = RW'($urandom); #1;
      n_tests++;
      if (rsp_valid !== oh || rsp_c !== cval || rsp_err !== 1'b0 || ALU_en !== 1'b0 || A !== '0 || req_ready !== 2'b00) begin
        n_fail++;
        $display("FAIL resp: rv=%b c=%h err=%b en=%b A=%h rdy=%b, expected rv=%b c=%h err=0 en=0 A=0 rdy=00",
                 rsp_valid, rsp_c, rsp_err, ALU_en, A, req_ready, oh, cval);
      end
      step;
    end
    rsp_ready = 2'b00; req_valid = 2'b00; C_en = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00; C_en = 1'b0; C = '0;
    step; step;
    rst_n = 1'b1; m_last = 1'b1;
  endtask

  task automatic test_reset;
    rand_ops;
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00; C_en = 1'b0; C = '0;
    step;
    n_tests++;
    if ({req_ready, rsp_valid, rsp_c, rsp_err, ALU_en, A, B, a_en, a_op, b_en, b_op} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b rv=%b c=%h err=%b en=%b A=%h B=%h, expected all 0",
               req_ready, rsp_valid, rsp_c, rsp_err, ALU_en, A, B);
    end
    rst_n = 1'b1; m_last = 1'b1;
    // C_en in IDLE must be ignored
    C_en = 1'b1; C = 6'h15;
    for (int i = 0; i < 3; i++) step;
    n_tests++;
    if (rsp_valid !== 2'b00 || ALU_en !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_c_en: rv=%b en=%b, expected rv=00 en=0", rsp_valid, ALU_en);
    end
    C_en = 1'b0;
  endtask

  task automatic test_t1;
    int p;
    rand_ops;
    oa[0] = 5'd5; ob[0] = 5'd3; oae[0] = 1'b1; oao[0] = 3'd0; cval = 6'd8;
    run_op(2'b01, 2, 0, p);
    n_tests++;
    if (p != 0) begin n_fail++; $display("FAIL t1_port: got %0d, expected 0", p); end
  endtask

  task automatic test_t2;
    int p0, p1;
    do_reset;
    rand_ops; run_op(2'b11, 1, 0, p0);
    rand_ops; run_op(2'b11, 1, 0, p1);
    n_tests++;
    if (p0 != 0 || p1 != 1) begin
      n_fail++; $display("FAIL t2_order: got %0d,%0d, expected 0,1", p0, p1);
    end
  endtask

  task automatic test_alternate;
    int p;
    for (int i = 0; i < 6; i++) begin
      rand_ops;
      run_op(2'b11, 1 + int'($urandom_range(0, 2)), 0, p);
      n_tests++;
      if (p != (i % 2)) begin n_fail++; $display("FAIL t3_alt[%0d]: got %0d, expected %0d", i, p, i % 2); end
    end
  endtask

  task automatic test_resp_hold;
    int p;
    rand_ops;
    run_op(2'($urandom_range(1, 3)), 2, 5, p);
  endtask

  task automatic test_random;
    int p;
    for (int i = 0; i < 30; i++) begin
      rand_ops;
      run_op(2'($urandom_range(1, 3)), int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), p);
    end
  endtask

  task automatic test_reset_busy;
    int p;
    rand_ops;
    req_valid = 2'b11; step;  // handshake
    step;                     // mid-BUSY
    rst_n = 1'b0; #1;
    n_tests++;
    if (ALU_en !== 1'b0 || A !== '0 || B !== '0 || rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL t5_async: en=%b A=%h B=%h rv=%b rdy=%b, expected all 0", ALU_en, A, B, rsp_valid, req_ready);
    end
    step;
    rst_n = 1'b1; req_valid = 2'b00; m_last = 1'b1;
    rand_ops;
    run_op(2'b11, 1, 0, p);
    n_tests++;
    if (p != 0) begin n_fail++; $display("FAIL t5_first_grant: got %0d, expected 0", p); end
  endtask

  task automatic test_timeout;
    int e;
    logic [1:0] oh;
    logic bad;
    rand_ops;
    e = exp_port(2'b01);
    oh = (e == 1) ? 2'b10 : 2'b01;
    req_valid = 2'b01; C_en = 1'b0; step;
    m_last = e[0]; req_valid = 2'b00;
`ifdef ALU_ARB_TIMEOUT_EN
    bad = 1'b0;
    for (int i = 0; i < TO; i++) begin
      if (ALU_en !== 1'b1 || rsp_valid !== 2'b00) bad = 1'b1;
      step;
    end
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL t6_busy_window: left BUSY before %0d cycles", TO); end
    n_tests++;
    if (rsp_valid !== oh || rsp_err !== 1'b1 || rsp_c !== '0 || ALU_en !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_timeout: rv=%b err=%b c=%h en=%b, expected rv=%b err=1 c=0 en=0", rsp_valid, rsp_err, rsp_c, ALU_en, oh);
    end
`else
    bad = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (ALU_en !== 1'b1 || rsp_valid !== 2'b00) bad = 1'b1;
      step;
    end
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL t6_wait: left BUSY without C_en, en=%b rv=%b", ALU_en, rsp_valid); end
    C_en = 1'b1; C = cval; step; C_en = 1'b0;
    n_tests++;
    if (rsp_valid !== oh || rsp_err !== 1'b0 || rsp_c !== cval) begin
      n_fail++;
      $display("FAIL t6_late_c: rv=%b err=%b c=%h, expected rv=%b err=0 c=%h", rsp_valid, rsp_err, rsp_c, oh, cval);
    end
`endif
    rsp_ready = oh; step; rsp_ready = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00; C_en = 1'b0; C = '0;
    m_last = 1'b1;
    rand_ops;
    test_reset;
    test_t1;
    test_t2;
    test_alternate;
    test_resp_hold;
    test_random;
    test_reset_busy;
    test_timeout;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
